// File: rtl/cpu_clk_pkg.sv
// Shared encodings for the CPU clock-enable controller: Mode input values and FSM states.
package cpu_clk_pkg;

  typedef enum logic [1:0] {
    MODE_PAUSE   = 2'd0,
    MODE_RUN     = 2'd1,
    MODE_STEP    = 2'd2,
    MODE_RUN_ALT = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_PAUSE = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2
  } state_e;

  function automatic state_e mode_to_state(input logic [1:0] m);
    case (mode_e'(m))
      MODE_RUN, MODE_RUN_ALT: return ST_RUN;
      MODE_STEP:              return ST_STEP;
      default:                return ST_PAUSE;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Step-button synchroniser and debouncer; emits the debounced level and a one-cycle
// rise pulse that is high in the same cycle the level first reads 1.
module btn_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 500000
) (
  input  logic CLOCK_50,
  input  logic Reset_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_rise
);

  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [SYNC_STAGES-1:0] sync;
  logic [DEB_W-1:0]       cnt;
  logic                   btn_s;
  logic                   hit;

  assign btn_s = sync[SYNC_STAGES-1];
  assign hit   = (cnt == DEB_W'(DEB_CYCLES - 1));

  always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
    if (!Reset_n) sync <= '0;
    else          sync <= {sync[SYNC_STAGES-2:0], btn_raw};
  end

  // Counter only runs while the synchronised input disagrees with the accepted level.
  always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt       <= '0;
      btn_level <= 1'b0;
      btn_rise  <= 1'b0;
    end else begin
      btn_rise <= 1'b0;
      if (btn_s != btn_level) begin
        if (hit) begin
          btn_level <= btn_s;
          btn_rise  <= btn_s;
          cnt       <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/cpu_clock_ctrl.sv
// Clock-enable controller for the CPU core: PAUSE / RUN (programmable divisor) / STEP,
// with Halt gating. Define CPU_CLK_TICKCNT_EN to build the TickCount counter.
module cpu_clock_ctrl
  import cpu_clk_pkg::*;
#(
  parameter int DIV_W       = 24,
  parameter int DEB_CYCLES  = 500000,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             CLOCK_50,
  input  logic             Reset_n,
  input  logic [1:0]       Mode,
  input  logic [DIV_W-1:0] Div,
  input  logic             StepBtn,
  input  logic             Halt,
  output logic             CpuEn,
  output logic             Heartbeat,
  output logic             BtnLevel,
  output logic [CNT_W-1:0] TickCount
);

  logic             btn_rise;
  state_e           state, state_nx;
  logic [DIV_W-1:0] cnt, cnt_cur, cnt_nx;
  logic             step_req, step_req_nx;
  logic             en_nx;

  btn_debounce #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEB_CYCLES  (DEB_CYCLES)
  ) u_deb (
    .CLOCK_50  (CLOCK_50),
    .Reset_n   (Reset_n),
    .btn_raw   (StepBtn),
    .btn_level (BtnLevel),
    .btn_rise  (btn_rise)
  );

  always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= ST_PAUSE;
      cnt       <= '0;
      step_req  <= 1'b0;
      CpuEn     <= 1'b0;
      Heartbeat <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      step_req  <= step_req_nx;
      CpuEn     <= en_nx;
      Heartbeat <= Heartbeat ^ en_nx;
    end
  end

  always_comb begin
    state_nx    = mode_to_state(Mode);
    cnt_nx      = '0;
    en_nx       = 1'b0;
    step_req_nx = step_req;
    cnt_cur     = (state == ST_RUN) ? cnt : '0;

    // An edge under Halt is discarded; a pending request absorbs further edges.
    if (btn_rise) step_req_nx = !Halt;

    case (state_nx)
      ST_RUN: begin
        if (Halt)                cnt_nx = '0;
        else if (cnt_cur >= Div) en_nx  = 1'b1;
        else                     cnt_nx = cnt_cur + 1'b1;
      end
      ST_STEP: begin
        if (!Halt && (step_req || btn_rise)) begin
          en_nx       = 1'b1;
          step_req_nx = 1'b0;
        end
      end
      default: ;
    endcase

    if (state_nx != state && state_nx != ST_STEP) step_req_nx = 1'b0;
  end

`ifdef CPU_CLK_TICKCNT_EN
  logic [CNT_W-1:0] tick_cnt;

  always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
    if (!Reset_n)   tick_cnt <= '0;
    else if (en_nx) tick_cnt <= tick_cnt + 1'b1;
  end

  assign TickCount = tick_cnt;
`else
  assign TickCount = '0;
`endif

endmodule

// File: doc/cpu_clock_ctrl.md
# cpu_clock_ctrl

Parametrised clock-enable controller between the 50 MHz board clock and the microprocessor core. It replaces the fixed toggle-divider with a single-domain clock-enable pulse, a runtime-programmable divisor, a debounced single-step button, and Halt gating. The core runs on CLOCK_50 and advances only on cycles where CpuEn is high.

## Interface
- DIV_W, 24: width of the divisor input Div.
- DEB_CYCLES, 500000: consecutive stable cycles required to accept a button level change (10 ms at 50 MHz); must be ≥1.
- SYNC_STAGES, 2: flip-flop stages in the StepBtn synchroniser; must be ≥2.
- CNT_W, 16: width of TickCount.

Ports:
- CLOCK_50  in  1  sole clock, rising edge.
- Reset_n  in  1  reset, asynchronous assert, active-low; deassertion is synchronous to CLOCK_50 upstream.
- Mode  in  2  0 = PAUSE, 1 = RUN, 2 = STEP, 3 = RUN (alias).
- Div  in  DIV_W  RUN tick period minus one, in CLOCK_50 cycles.
- StepBtn  in  1  raw, asynchronous, active-high step button.
- Halt  in  1  core halted; suppresses all CpuEn while high.
- CpuEn  out  1  registered one-cycle clock-enable to the core.
- Heartbeat  out  1  toggles on every CpuEn pulse, for an LED.
- BtnLevel  out  1  debounced StepBtn level.
- TickCount  out  CNT_W  CpuEn pulses issued since reset; wraps.

## Operation
- **Reset values.** All outputs are 0. The state is PAUSE, the divider count is 0, the step request is clear, and the debounced level is 0.
- **Synchroniser.** StepBtn passes through SYNC_STAGES flip-flops.
- **Debouncer.** A counter increments while the synchronised level differs from BtnLevel and clears when they match. When the counter reaches DEB_CYCLES-1, BtnLevel takes the new level and the counter clears.
- **Step request.** A rising edge of BtnLevel sets a one-deep step request. Further edges while the request is pending are dropped. The request clears when it is consumed, on entry to PAUSE or RUN, or on any edge seen while Halt=1.
- **State machine (PAUSE, RUN, STEP).** The state follows Mode every cycle. Entering RUN clears the divider count.
- **PAUSE.** CpuEn=0. The divider is held at 0.
- **RUN.** Each cycle:
  - If Halt=1: the count is held at 0 and CpuEn=0.
  - Else if count ≥ Div: CpuEn=1 and the count returns to 0.
  - Else: the count increments.
  - Div=0 gives a continuous enable.
  - Lowering Div mid-count below the current count fires on the next cycle (≥ compare, no wrap).
- **STEP.** If the request is set and Halt=0, CpuEn=1 for exactly one cycle and the request clears. The divider is held at 0.
- **Heartbeat and TickCount.** Heartbeat toggles and TickCount increments, modulo 2^CNT_W, in the same cycle CpuEn is asserted.
- **Halt.** Halt has priority over every mode.

## Timing
- CpuEn is registered: its decision uses inputs sampled on edge N and appears after edge N.
- **RUN.** The first CpuEn is high Div+1 cycles after the first cycle in RUN; after that it is one cycle high every Div+1 cycles.
- **Button to BtnLevel.** A raw button edge held stable reaches BtnLevel after SYNC_STAGES+DEB_CYCLES cycles.
- **Step.** In STEP, CpuEn follows the BtnLevel rising edge by 1 cycle, or by 0 cycles if the request is already pending on entry to STEP.
- **Halt.** Halt rising suppresses CpuEn from the next registered output onward.
- **Reset mid-operation.** All state and outputs go to reset values immediately. A pending step is lost, and an in-progress debounce restarts.

## Configuration
- **CPU_CLK_TICKCNT_EN defined.** The TickCount counter is implemented as above.
- **CPU_CLK_TICKCNT_EN undefined.** TickCount is tied to 0 and no counter flops are generated. All other behaviour is identical.

## Structure
- **Package `cpu_clk_pkg`.** Holds the Mode encodings as a 2-bit enum (MODE_PAUSE, MODE_RUN, MODE_STEP, MODE_RUN_ALT) and the state enum (ST_PAUSE, ST_RUN, ST_STEP).
- **Sub-module `btn_debounce`.** Takes SYNC_STAGES and DEB_CYCLES. Inputs: CLOCK_50, Reset_n, raw button. Outputs: debounced level and a one-cycle rise pulse. The top level keeps the FSM, divider, step request and counters.

## Test plan
- **Reset and run.** Reset_n low, then release with Mode=RUN, Div=3 → all outputs 0 during reset; CpuEn pulses every 4 cycles, first pulse 4 cycles after entry; Heartbeat toggles per pulse; TickCount=5 after 5 pulses.
- **Continuous enable and Div change.** Mode=RUN, Div=0 → CpuEn high every cycle. Then Div changes from 10 to 2 while count=7 → CpuEn next cycle, then every 3 cycles.
- **Debounce.** DEB_CYCLES=8, StepBtn bounces 0/1 every 3 cycles, then held 1 → BtnLevel rises exactly 8 cycles after the final stable edge plus SYNC_STAGES.
- **Single step.**
  - Mode=STEP, one clean press → exactly one CpuEn.
  - Two presses before consumption, entered from PAUSE → one CpuEn.
  - Press with Halt=1 → no CpuEn, even after Halt drops.
- **Halt and reset mid-operation.** Mode=RUN, Div=5: Halt=1 mid-count → no CpuEn; release Halt → next CpuEn 6 cycles later. Reset_n pulsed low mid-count → outputs 0 asynchronously, state PAUSE.
- **Configuration build.** Build with CPU_CLK_TICKCNT_EN undefined → TickCount stays 0 through 20 pulses. With it defined and CNT_W=4 → wraps from 15 to 0 on the 16th pulse.
